// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding and counter sizing for the debouncer
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  function automatic int cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/debounce_sync_chain.sv
// rtl/debounce_sync_chain.sv - N-flop synchroniser with synchronous clear
module sync_chain #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [N-1:0] ff;

  always_ff @(posedge clk) begin
    if (reset) begin
      ff <= '0;
    end else begin
      ff <= {ff[N-2:0], d};
    end
  end

  assign q = ff[N-1];

endmodule

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - synchronise a bouncing raw input and emit a clean level plus edge pulses
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic din_raw,
  output logic dout,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_out;
  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          dout_nx, rise_nx, fall_nx, busy_nx;

  sync_chain #(.N(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (din_raw),
    .q     (sync_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= STABLE_LO;
      cnt        <= '0;
      dout       <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      dout       <= dout_nx;
      rise_pulse <= rise_nx;
      fall_pulse <= fall_nx;
      busy       <= busy_nx;
    end
  end

  // Any reversal during a WAIT state drops back to the stable state with the count cleared.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    dout_nx  = dout;
    rise_nx  = 1'b0;
    fall_nx  = 1'b0;
    case (state)
      STABLE_LO: begin
        if (sync_out) begin
          state_nx = WAIT_HI;
          cnt_nx   = '0;
        end
      end
      WAIT_HI: begin
        if (!sync_out) begin
          state_nx = STABLE_LO;
          cnt_nx   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nx = STABLE_HI;
          cnt_nx   = '0;
          dout_nx  = 1'b1;
          rise_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      STABLE_HI: begin
        if (!sync_out) begin
          state_nx = WAIT_LO;
          cnt_nx   = '0;
        end
      end
      WAIT_LO: begin
        if (sync_out) begin
          state_nx = STABLE_HI;
          cnt_nx   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nx = STABLE_LO;
          cnt_nx   = '0;
          dout_nx  = 1'b0;
          fall_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
    endcase
    busy_nx = (state_nx == WAIT_HI) || (state_nx == WAIT_LO);
  end

endmodule
